round_robin_arbiter: RTL

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/round_robin_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package rr_arb_pkg;

  localparam int DEFAULT_N        = 8;
  localparam int DEFAULT_MAX_HOLD = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: first set req bit at ptr, ptr+1, ... wrapping at N.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  always_comb begin
    logic [W-1:0] j;
    found = 1'b0;
    index = '0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = W'((32'(ptr) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        index = j;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with hold limit; one owner at a time, one idle cycle between grants.
module round_robin_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id,
  output logic         timeout
);

  state_t       state, state_n;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] gnt_id_n;
  logic [7:0]   cnt, cnt_n;
  logic         timeout_n;
  logic         found;
  logic [W-1:0] pick_idx;
  logic         expired;
  logic         grant_end;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .index (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_id  <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_id  <= gnt_id_n;
      cnt     <= cnt_n;
      timeout <= timeout_n;
    end
  end

  assign expired   = (cnt == 8'(MAX_HOLD));
  assign grant_end = rel || !req[gnt_id] || expired;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_id_n  = gnt_id;
    cnt_n     = cnt;
    timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n  = GRANT;
          gnt_id_n = pick_idx;
          cnt_n    = 8'd1;
        end
      end
      GRANT: begin
        if (grant_end) begin
          // Timeout only when expiry is the sole reason the grant ends.
          state_n   = IDLE;
          gnt_id_n  = '0;
          cnt_n     = '0;
          ptr_n     = (gnt_id == W'(N - 1)) ? '0 : gnt_id + W'(1);
          timeout_n = expired && !rel && req[gnt_id];
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state == GRANT);
  end

  for (genvar k = 0; k < N; k++) begin : g_dec
    assign gnt[k] = gnt_valid && (gnt_id == W'(k));
  end

endmodule
